fw_cfg_chain_seq: RTL and testbench

// - Sequencer for the DUT configuration scan chain. Drives fw_config_clk, fw_config_in and fw_config_load.
// - Serializes the first cfg_n_words words of the config_array register bank into the chain.
// - Finishes each run with one load strobe. Sits in fw_ip2 beside the bxclk generator.
// - A start pulse (op_code_w_execute, qualified by the parent) launches one run. busy/done feed fw_read_status32.

---
 rtl/fw_cfg_chain_seq.sv | 202 ++++++++++++++++++++
 tb/tb_fw_cfg_chain_seq.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fw_cfg_chain_seq.sv
// fw_cfg_chain_seq: DUT configuration scan-chain sequencer (fw_ip2).
// Define FW_CFG_CHAIN_READBACK_EN to add chain readback (rb_word/rb_valid/rb_index).
module fw_cfg_chain_seq #(
    parameter int N_WORDS = 256,
    parameter int WORD_W  = 16,
    parameter int CNT_W   = 12
) (
    input  logic                           fw_pl_clk1,
    input  logic                           fw_rst,
    input  logic                           op_code_w_reset,
    input  logic                           start,
    input  logic [7:0]                     cfg_half_period,
    input  logic [8:0]                     cfg_n_words,
    input  logic [N_WORDS-1:0][WORD_W-1:0] config_array,
    output logic                           fw_config_clk,
    output logic                           fw_config_in,
    output logic                           fw_config_load,
    input  logic                           fw_config_out,
    output logic                           busy,
    output logic                           done,
    output logic [CNT_W-1:0]               bit_cnt
`ifdef FW_CFG_CHAIN_READBACK_EN
    ,
    output logic [WORD_W-1:0]              rb_word,
    output logic                           rb_valid,
    output logic [8:0]                     rb_index
`endif
);

    localparam int IDX_W = $clog2(N_WORDS);
    localparam int BP_W  = $clog2(WORD_W);
    localparam logic [9:0] NW_MAX = 10'(N_WORDS);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        LOAD_SU,
        LOAD,
        FIN
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [7:0]        h_q;
    logic [7:0]        hcnt;
    logic [7:0]        h_eff;
    logic [8:0]        nw_eff;
    logic [IDX_W-1:0]  first_idx;
    logic [IDX_W-1:0]  word_idx;
    logic [BP_W-1:0]   bit_pos;
    logic [WORD_W-1:0] sr;
    logic              phase_end;
    logic              last_bit;
    logic              last_word;
    logic              launch;
    logic              bit_done;

    // Run parameters are only consumed at launch and then held in h_q/word_idx.
    assign h_eff     = (cfg_half_period == 8'd0) ? 8'd1 : cfg_half_period;
    assign nw_eff    = (cfg_n_words == 9'd0 || {1'b0, cfg_n_words} > NW_MAX)
                       ? NW_MAX[8:0] : cfg_n_words;
    assign first_idx = IDX_W'(nw_eff - 9'd1);
    assign phase_end = (hcnt == 8'd0);
    assign last_bit  = (bit_pos == BP_W'(WORD_W - 1));
    assign last_word = (word_idx == '0);
    assign launch    = (state_q == IDLE) && start;
    assign bit_done  = (state_q == SHIFT_HI) && phase_end;

    always_ff @(posedge fw_pl_clk1 or posedge fw_rst) begin
        if (fw_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (start) state_d = SHIFT_LO;
            SHIFT_LO: if (phase_end) state_d = SHIFT_HI;
            SHIFT_HI: begin
                if (phase_end) begin
                    state_d = (last_bit && last_word) ? LOAD_SU : SHIFT_LO;
                end
            end
            LOAD_SU:  if (phase_end) state_d = LOAD;
            LOAD:     if (phase_end) state_d = FIN;
            FIN:      state_d = IDLE;
            default:  state_d = IDLE;
        endcase
        if (op_code_w_reset) state_d = IDLE;
    end

    always_comb begin
        fw_config_clk  = 1'b0;
        fw_config_in   = 1'b0;
        fw_config_load = 1'b0;
        busy           = 1'b0;
        done           = 1'b0;
        unique case (state_q)
            SHIFT_LO: begin
                fw_config_in = sr[WORD_W-1];
                busy         = 1'b1;
            end
            SHIFT_HI: begin
                fw_config_clk = 1'b1;
                fw_config_in  = sr[WORD_W-1];
                busy          = 1'b1;
            end
            LOAD_SU: busy = 1'b1;
            LOAD: begin
                fw_config_load = 1'b1;
                busy           = 1'b1;
            end
            FIN:     done = 1'b1;
            default: ;
        endcase
    end

    // Phase counter reloads on every state change, so each phase lasts H cycles.
    always_ff @(posedge fw_pl_clk1 or posedge fw_rst) begin
        if (fw_rst) begin
            h_q  <= 8'd0;
            hcnt <= 8'd0;
        end else if (op_code_w_reset) begin
            h_q  <= 8'd0;
            hcnt <= 8'd0;
        end else begin
            if (launch) h_q <= h_eff;
            if (state_d != state_q) begin
                hcnt <= (launch ? h_eff : h_q) - 8'd1;
            end else if (!phase_end) begin
                hcnt <= hcnt - 8'd1;
            end
        end
    end

    // Words are latched one at a time so later words may still be rewritten.
    always_ff @(posedge fw_pl_clk1 or posedge fw_rst) begin
        if (fw_rst) begin
            word_idx <= '0;
            bit_pos  <= '0;
            sr       <= '0;
            bit_cnt  <= '0;
        end else if (op_code_w_reset) begin
            word_idx <= '0;
            bit_pos  <= '0;
            sr       <= '0;
            bit_cnt  <= '0;
        end else if (launch) begin
            word_idx <= first_idx;
            bit_pos  <= '0;
            sr       <= config_array[first_idx];
            bit_cnt  <= '0;
        end else if (bit_done) begin
            bit_cnt <= bit_cnt + CNT_W'(1);
            if (last_bit) begin
                bit_pos <= '0;
                if (!last_word) begin
                    word_idx <= word_idx - 1'b1;
                    sr       <= config_array[word_idx - 1'b1];
                end else begin
                    sr <= '0;
                end
            end else begin
                bit_pos <= bit_pos + 1'b1;
                sr      <= {sr[WORD_W-2:0], 1'b0};
            end
        end
    end

`ifdef FW_CFG_CHAIN_READBACK_EN
    // Sample just before the falling edge, after the DUT has had the whole high phase.
    always_ff @(posedge fw_pl_clk1 or posedge fw_rst) begin
        if (fw_rst) begin
            rb_word  <= '0;
            rb_valid <= 1'b0;
            rb_index <= 9'd0;
        end else if (op_code_w_reset) begin
            rb_word  <= '0;
            rb_valid <= 1'b0;
            rb_index <= 9'd0;
        end else begin
            rb_valid <= 1'b0;
            if (bit_done) begin
                rb_word <= {rb_word[WORD_W-2:0], fw_config_out};
                if (last_bit) begin
                    rb_valid <= 1'b1;
                    rb_index <= 9'(word_idx);
                end
            end
        end
    end
`else
    logic unused_cfg_out;
    assign unused_cfg_out = fw_config_out;
`endif

endmodule

// File: tb/tb_fw_cfg_chain_seq.sv
// Bench for fw_cfg_chain_seq: vector table, hand sequences, random runs.
// Readback checks compile in when FW_CFG_CHAIN_READBACK_EN is defined.
`timescale 1ns/1ps
module tb_fw_cfg_chain_seq;

    localparam int N_WORDS = 256;
    localparam int WORD_W  = 16;
    localparam int CNT_W   = $clog2(N_WORDS * WORD_W) + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic abort = 1'b0;
    logic start = 1'b0;
    logic [7:0] cfg_half_period = 8'd0;
    logic [8:0] cfg_n_words = 9'd0;
    logic [N_WORDS-1:0][WORD_W-1:0] cfg;
    logic fw_config_clk, fw_config_in, fw_config_load, fw_config_out;
    logic busy, done;
    logic [CNT_W-1:0] bit_cnt;
    int checks = 0;
    int errors = 0;

`ifdef FW_CFG_CHAIN_READBACK_EN
    logic [WORD_W-1:0] rb_word;
    logic              rb_valid;
    logic [8:0]        rb_index;
    logic [24:0]       rb_q[$];
    always @(negedge clk) if (rb_valid) rb_q.push_back({rb_index, rb_word});
`endif

    always #5 clk = ~clk;

    // 32-stage chain: captures on the rising config clock, advances on the falling one.
    logic [31:0] chain = 32'd0;
    logic        pend = 1'b0;
    always @(posedge fw_config_clk) pend = fw_config_in;
    always @(negedge fw_config_clk) chain = {chain[30:0], pend};
    assign fw_config_out = chain[31];

    fw_cfg_chain_seq #(
        .N_WORDS(N_WORDS),
        .WORD_W (WORD_W),
        .CNT_W  (CNT_W)
    ) dut (
        .fw_pl_clk1     (clk),
        .fw_rst         (rst),
        .op_code_w_reset(abort),
        .start          (start),
        .cfg_half_period(cfg_half_period),
        .cfg_n_words    (cfg_n_words),
        .config_array   (cfg),
        .fw_config_clk  (fw_config_clk),
        .fw_config_in   (fw_config_in),
        .fw_config_load (fw_config_load),
        .fw_config_out  (fw_config_out),
        .busy           (busy),
        .done           (done),
        .bit_cnt        (bit_cnt)
`ifdef FW_CFG_CHAIN_READBACK_EN
        ,
        .rb_word        (rb_word),
        .rb_valid       (rb_valid),
        .rb_index       (rb_index)
`endif
    );

    task automatic check(input string nm, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    // One run against the model; tbl_* < 0 means take the model's value.
    task automatic run_check(input string nm, input int h, input int n,
                             input int mid, input int chg,
                             input int tbl_bits, input int tbl_len,
                             output logic [15:0] first16);
        int he, nw, bits, len, k, got_len, rises, ld, bit_err, busy_err;
        int exp_bits, exp_len;
        bit exp_q[$];
        logic [N_WORDS-1:0][WORD_W-1:0] plan;
        logic prev;
        he = (h == 0) ? 1 : h;
        nw = (n == 0 || n > N_WORDS) ? N_WORDS : n;
        bits = nw * WORD_W;
        len = 1 + 2 * he * bits + 2 * he;
        exp_bits = (tbl_bits < 0) ? bits : tbl_bits;
        exp_len = (tbl_len < 0) ? len : tbl_len;
        plan = cfg;
        if (chg > 0) plan[0] = ~cfg[0];
        for (int w = nw - 1; w >= 0; w--)
            for (int b = WORD_W - 1; b >= 0; b--)
                exp_q.push_back(plan[w][b]);
        @(negedge clk);
        cfg_half_period = 8'(h);
        cfg_n_words = 9'(n);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 1; got_len = -1; rises = 0; ld = 0;
        bit_err = 0; busy_err = 0; prev = 1'b0; first16 = 16'd0;
        while (k <= exp_len + 20) begin
            if (fw_config_clk && !prev) begin
                if (rises < exp_q.size() && fw_config_in !== exp_q[rises])
                    bit_err++;
                if (rises < 16) first16 = {first16[14:0], fw_config_in};
                rises++;
            end
            prev = fw_config_clk;
            if (fw_config_load) ld++;
            if (done) begin
                got_len = k;
                if (busy) busy_err++;
                break;
            end
            if (!busy) busy_err++;
            start = (k == mid);
            if (chg > 0 && k == chg) begin
                cfg[0] = ~cfg[0];
                cfg[nw-1] = ~cfg[nw-1];
            end
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        check({nm, " len"}, got_len, exp_len);
        check({nm, " rises"}, rises, exp_bits);
        check({nm, " bit_errs"}, bit_err, 0);
        check({nm, " load_cycles"}, ld, he);
        check({nm, " busy_errs"}, busy_err, 0);
        check({nm, " bit_cnt"}, bit_cnt, exp_bits);
        @(negedge clk);
        check({nm, " done_low"}, done, 0);
        check({nm, " bit_cnt_hold"}, bit_cnt, exp_bits);
    endtask

    task automatic abort_test();
        int rises;
        logic prev;
        bit seen;
        @(negedge clk);
        cfg_half_period = 8'd1;
        cfg_n_words = 9'd4;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rises = 0;
        prev = 1'b0;
        for (int k = 0; k < 500; k++) begin
            if (fw_config_clk && !prev) rises++;
            prev = fw_config_clk;
            if (rises == 37) break;
            @(negedge clk);
        end
        check("abort reach_bit37", rises, 37);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort outputs",
              {fw_config_clk, fw_config_in, fw_config_load, busy, done}, 0);
        check("abort bit_cnt", bit_cnt, 0);
        seen = 1'b0;
        repeat (200) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        check("abort no_done", seen, 0);
    endtask

    task automatic async_rst_test();
        @(negedge clk);
        cfg_half_period = 8'd2;
        cfg_n_words = 9'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 200 && !fw_config_load; k++) @(negedge clk);
        check("arst reach_load", fw_config_load, 1);
        #2 rst = 1'b1;
        #1;
        check("arst outputs",
              {fw_config_clk, fw_config_in, fw_config_load, busy, done}, 0);
        check("arst bit_cnt", bit_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        int h;
        int n;
        int mid;
        int bits;
        int len;
    } vec_t;

    vec_t tbl[7];
    logic [15:0] f16;

    initial begin
        tbl[0] = '{2, 1, 0, 16, 69};
        tbl[1] = '{1, 0, 0, 4096, 8195};
        tbl[2] = '{0, 300, 0, 4096, 8195};
        tbl[3] = '{0, 2, 0, 32, 67};
        tbl[4] = '{1, 2, 20, 32, 67};
        tbl[5] = '{3, 3, 0, 48, 295};
        tbl[6] = '{255, 1, 0, 16, 8671};
        for (int w = 0; w < N_WORDS; w++) cfg[w] = 16'($urandom);
        cfg[0] = 16'hA5C3;

        repeat (3) @(negedge clk);
        check("reset outputs",
              {fw_config_clk, fw_config_in, fw_config_load, busy, done}, 0);
        check("reset bit_cnt", bit_cnt, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_check($sformatf("vec%0d", i), tbl[i].h, tbl[i].n, tbl[i].mid,
                      0, tbl[i].bits, tbl[i].len, f16);
            if (i == 0) check("vec0 A5C3 sequence", f16, 16'hA5C3);
        end

        run_check("midrun_change", 1, 3, 0, 5, -1, -1, f16);

        abort_test();
        run_check("after_abort", 1, 4, 0, 0, -1, -1, f16);

        async_rst_test();
        run_check("after_arst", 2, 1, 0, 0, -1, -1, f16);

        for (int i = 0; i < 12; i++) begin
            int h, n;
            h = $urandom_range(0, 4);
            n = $urandom_range(1, 6);
            for (int w = 0; w < 8; w++) cfg[w] = 16'($urandom);
            run_check($sformatf("rnd%0d", i), h, n, 0, 0, -1, -1, f16);
        end

`ifdef FW_CFG_CHAIN_READBACK_EN
        begin
            logic [24:0] g0, g1;
            cfg[1] = 16'h1234;
            cfg[0] = 16'hBEEF;
            run_check("rb_run1", 1, 2, 0, 0, -1, -1, f16);
            rb_q.delete();
            run_check("rb_run2", 1, 2, 0, 0, -1, -1, f16);
            check("rb pulses", rb_q.size(), 2);
            g0 = (rb_q.size() > 0) ? rb_q[0] : '1;
            g1 = (rb_q.size() > 1) ? rb_q[1] : '1;
            check("rb first", g0, {9'd1, 16'h1234});
            check("rb second", g1, {9'd0, 16'hBEEF});
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
